// File: rtl/program_memory_loader_if.sv
// program_memory_loader_if: byte-stream input and program-memory write bus of the loader
interface program_memory_loader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  Start;
    logic [10:0]           LoadLength;
    logic [7:0]            ByteData;
    logic                  ByteValid;
    logic                  ByteReady;
    logic                  WriteEnable;
    logic [DATA_WIDTH-1:0] WriteAddress;
    logic [DATA_WIDTH-1:0] WriteData;
    logic                  Busy;
    logic                  CpuHold;
    logic                  Done;
    logic                  Error;

    modport master (
        output Start, LoadLength, ByteData, ByteValid,
        input  ByteReady, WriteEnable, WriteAddress, WriteData, Busy, CpuHold, Done, Error
    );

    modport slave (
        input  Start, LoadLength, ByteData, ByteValid,
        output ByteReady, WriteEnable, WriteAddress, WriteData, Busy, CpuHold, Done, Error
    );
endinterface

// File: rtl/program_memory_loader.sv
// program_memory_loader: assembles a big-endian byte stream into words and writes them to program memory
module program_memory_loader #(
    parameter int MEMORY_DEPTH = 32,
    parameter int DATA_WIDTH   = 32
) (
    input logic                    clk,
    input logic                    reset,
    program_memory_loader_if.slave bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IW    = MEMORY_DEPTH > 1 ? $clog2(MEMORY_DEPTH) : 1;
    localparam int BW    = BYTES > 1 ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         word_idx_q, word_idx_d;
    logic [IW-1:0]         last_idx_q, last_idx_d;
    logic [BW-1:0]         byte_idx_q, byte_idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  error_q, error_d;
    logic                  bad_len;

    assign bad_len = bus.LoadLength == '0 || bus.LoadLength > 11'(MEMORY_DEPTH);

    // Next-state logic: session start, byte shifting, and word write sequencing
    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        last_idx_d = last_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        data_d     = data_q;
        error_d    = error_q;
        case (state_q)
            IDLE: begin
                if (bus.Start && bad_len) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else if (bus.Start) begin
                    error_d    = 1'b0;
                    last_idx_d = IW'(bus.LoadLength - 11'd1);
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    shift_d    = '0;
                    state_d    = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.ByteValid) begin
                    shift_d    = DATA_WIDTH'({shift_q, bus.ByteData});
                    byte_idx_d = byte_idx_q + 1'b1;
                    if (byte_idx_q == BW'(BYTES - 1)) begin
                        byte_idx_d = '0;
                        addr_d     = DATA_WIDTH'({word_idx_q, 2'b00});
                        data_d     = shift_d;
                        state_d    = WRITE;
                    end
                end
            end
            WRITE: begin
                state_d    = word_idx_q == last_idx_q ? DONE : COLLECT;
                word_idx_d = word_idx_q == last_idx_q ? word_idx_q : word_idx_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any partial word
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            word_idx_q <= '0;
            last_idx_q <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            last_idx_q <= last_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            error_q    <= error_d;
        end
    end

    assign bus.ByteReady    = state_q == COLLECT;
    assign bus.WriteEnable  = state_q == WRITE;
    assign bus.Done         = state_q == DONE;
    assign bus.Busy         = state_q != IDLE;
    assign bus.CpuHold      = state_q != IDLE;
    assign bus.Error        = error_q;
    assign bus.WriteAddress = addr_q;
    assign bus.WriteData    = data_q;
endmodule
